// File: rtl/demux_pkg.sv
// Shared lane-indexing constants, the lane state type and the {group, lane}
// address helper for the 8-way demultiplexer.
package demux_pkg;

    localparam int NUM_LANES     = 8;
    localparam int LANE_IDX_W    = 3;
    localparam int GROUP_BIT     = 2;
    localparam int LANE_IN_GRP_W = GROUP_BIT;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    function automatic logic [LANE_IDX_W-1:0] lane_of(
        input logic                     group,
        input logic [LANE_IN_GRP_W-1:0] idx
    );
        return {group, idx};
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry output buffer for a single demux lane with valid/ready drain.
//
//   state      | meaning
//   LANE_EMPTY | no word held, out_valid low
//   LANE_FULL  | word held in out_data, out_valid high until drained
module demux_lane
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    lane_state_e state, state_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LANE_EMPTY;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data <= load_data;
            end
        end
    end

    // A load in the same cycle as a drain keeps the lane full with the new word.
    always_comb begin
        state_nxt = state;
        case (state)
            LANE_EMPTY: begin
                if (load) begin
                    state_nxt = LANE_FULL;
                end
            end
            LANE_FULL: begin
                if (!load && out_ready) begin
                    state_nxt = LANE_EMPTY;
                end
            end
            default: state_nxt = LANE_EMPTY;
        endcase
    end

    assign out_valid = (state == LANE_FULL);

endmodule

// File: rtl/demux_8way.sv
// Registered 1-to-8 demultiplexer: routes one producer word per cycle into one
// of eight independently drained single-word lanes.
module demux_8way
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANE_IDX_W-1:0]       in_sel,
    input  logic [DATA_W-1:0]           in_data,
    output logic [NUM_LANES-1:0]        out_valid,
    input  logic [NUM_LANES-1:0]        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic                        busy,
    output logic [CNT_W-1:0]            acc_cnt
);

    logic [LANE_IDX_W-1:0] lane_sel;
    logic [NUM_LANES-1:0]  load;
    logic                  accept;

    assign lane_sel = lane_of(in_sel[GROUP_BIT], in_sel[LANE_IN_GRP_W-1:0]);

    // A full lane can still accept if its consumer empties it this cycle.
    assign in_ready = rst_n & (~out_valid[lane_sel] | out_ready[lane_sel]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            load[lane_sel] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[i]),
            .load_data (in_data),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    assign busy = |out_valid;

endmodule

// File: tb/tb_demux_8way.sv
// Randomized and directed bench for demux_8way against a lane-array model;
// a second instance with a 4-bit counter exercises counter wrap.
module tb_demux_8way;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_sel;
    logic [7:0]  in_data;
    logic [7:0]  out_ready;

    logic        in_ready,  in_ready4;
    logic [7:0]  out_valid, out_valid4;
    logic [63:0] out_data,  out_data4;
    logic        busy,      busy4;
    logic [15:0] acc_cnt;
    logic [3:0]  acc_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    bit       m_full [8];
    bit [7:0] m_data [8];
    int       m_cnt;
    bit       last_acc;

    always #5 clk = ~clk;

    demux_8way #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .acc_cnt(acc_cnt)
    );

    demux_8way #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .busy(busy4), .acc_cnt(acc_cnt4)
    );

    function automatic bit model_ready();
        return rst_n && (!m_full[in_sel] || out_ready[in_sel]);
    endfunction

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    // Advance one clock: sample inputs, let the edge pass, update the model,
    // and return at the following falling edge.
    task automatic tick();
        bit       rst_s, acc;
        bit [2:0] s;
        bit [7:0] d, ordy;
        rst_s = rst_n;
        s     = in_sel;
        d     = in_data;
        ordy  = out_ready;
        acc   = in_valid && model_ready();
        @(posedge clk);
        if (!rst_s) begin
            for (int i = 0; i < 8; i++) begin
                m_full[i] = 0;
                m_data[i] = 8'h00;
            end
            m_cnt = 0;
            acc   = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (m_full[i] && ordy[i]) m_full[i] = 0;
            if (acc) begin
                m_full[s] = 1;
                m_data[s] = d;
                m_cnt     = m_cnt + 1;
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 1; in_sel = 3'd4; in_data = 8'h11; out_ready = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL reset_in_ready cyc%0d got %b want 0", c, in_ready);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 8'h00 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %h busy %b want 00/0", out_valid, busy);
        end
        n_cmp++;
        if (acc_cnt !== 16'd0 || acc_cnt4 !== 4'd0) begin
            n_err++; $display("FAIL reset_cnt got %0d/%0d want 0", acc_cnt, acc_cnt4);
        end
        n_cmp++;
        if (out_data !== 64'd0) begin
            n_err++; $display("FAIL reset_data got %h want 0", out_data);
        end
        rst_n = 1; in_valid = 0;
        tick();
    endtask

    task automatic test_single_route();
        in_valid = 1; in_sel = 3'b101; in_data = 8'hA5; out_ready = 8'h00;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL route_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 8'h20 || busy !== 1'b1) begin
            n_err++; $display("FAIL route_valid got %h busy %b want 20/1", out_valid, busy);
        end
        n_cmp++;
        if (out_data[5*DW +: DW] !== 8'hA5) begin
            n_err++; $display("FAIL route_data got %h want a5", out_data[5*DW +: DW]);
        end
        n_cmp++;
        if (acc_cnt !== 16'd1) begin
            n_err++; $display("FAIL route_cnt got %0d want 1", acc_cnt);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1; in_sel = 3'd5; in_data = 8'h3C; out_ready = 8'h00;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_stall_ready got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 8'h20 || out_data[5*DW +: DW] !== 8'hA5 || acc_cnt !== 16'd1) begin
            n_err++; $display("FAIL bp_hold got v=%h d=%h c=%0d want 20/a5/1",
                              out_valid, out_data[5*DW +: DW], acc_cnt);
        end
        in_sel = 3'd2; in_data = 8'h5A;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_retarget_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 8'h24 || out_data[2*DW +: DW] !== 8'h5A) begin
            n_err++; $display("FAIL bp_lane2 got v=%h d=%h want 24/5a",
                              out_valid, out_data[2*DW +: DW]);
        end
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
        n_cmp++;
        if (out_valid !== 8'h00 || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_drain got v=%h busy %b want 00/0", out_valid, busy);
        end
    endtask

    task automatic test_streaming();
        int acc_seen = 0;
        in_sel = 3'd0; out_ready = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1; in_data = 8'(k);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL stream_ready word%0d got %b want 1", k, in_ready);
            end
            tick();
            if (last_acc) acc_seen++;
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data[DW-1:0] !== 8'(k)) begin
                n_err++; $display("FAIL stream_word%0d got v=%b d=%0d want 1/%0d",
                                  k, out_valid[0], out_data[DW-1:0], k);
            end
        end
        in_valid = 0;
        tick();
        n_cmp++;
        if (acc_seen != 10 || out_valid[0] !== 1'b0 || acc_cnt !== 16'(m_cnt)) begin
            n_err++; $display("FAIL stream_end got acc=%0d v=%b cnt=%0d want 10/0/%0d",
                              acc_seen, out_valid[0], acc_cnt, m_cnt);
        end
        out_ready = 8'h00;
    endtask

    task automatic test_counter_wrap();
        rst_n = 0; in_valid = 0;
        tick();
        rst_n = 1; in_sel = 3'd3; out_ready = 8'hFF;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1; in_data = 8'($urandom_range(0, 255));
            tick();
        end
        in_valid = 0;
        n_cmp++;
        if (acc_cnt4 !== 4'd1) begin
            n_err++; $display("FAIL wrap_cnt4 got %0d want 1", acc_cnt4);
        end
        n_cmp++;
        if (acc_cnt !== 16'd17) begin
            n_err++; $display("FAIL wrap_cnt16 got %0d want 17", acc_cnt);
        end
        tick();
        out_ready = 8'h00;
    endtask

    task automatic test_midstream_reset();
        in_valid = 1; in_sel = 3'd1; in_data = 8'h61;
        tick();
        in_sel = 3'd6; in_data = 8'h66;
        tick();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 8'h42) begin
            n_err++; $display("FAIL mid_pre got %h want 42", out_valid);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        n_cmp++;
        if (out_valid !== 8'h00 || out_data !== 64'd0 || acc_cnt !== 16'd0) begin
            n_err++; $display("FAIL mid_reset got v=%h d=%h c=%0d want 0/0/0",
                              out_valid, out_data, acc_cnt);
        end
        in_valid = 1; in_sel = 3'd4; in_data = 8'h77;
        tick();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 8'h10 || out_data[4*DW +: DW] !== 8'h77 || acc_cnt !== 16'd1) begin
            n_err++; $display("FAIL mid_after got v=%h d=%h c=%0d want 10/77/1",
                              out_valid, out_data[4*DW +: DW], acc_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!(in_valid && !last_acc)) begin
                in_valid = 1'($urandom);
                in_sel   = 3'($urandom);
                in_data  = 8'($urandom);
            end
            out_ready = 8'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== model_ready() || in_ready4 !== model_ready()) begin
                n_err++; $display("FAIL rand_ready cyc%0d got %b/%b want %b",
                                  c, in_ready, in_ready4, model_ready());
            end
            tick();
            n_cmp++;
            if (out_valid !== model_valid() || busy !== (|model_valid())) begin
                n_err++; $display("FAIL rand_valid cyc%0d got %h busy %b want %h",
                                  c, out_valid, busy, model_valid());
            end
            for (int i = 0; i < 8; i++) begin
                if (m_full[i]) begin
                    n_cmp++;
                    if (out_data[i*DW +: DW] !== m_data[i]) begin
                        n_err++; $display("FAIL rand_data cyc%0d lane%0d got %h want %h",
                                          c, i, out_data[i*DW +: DW], m_data[i]);
                    end
                end
            end
            n_cmp++;
            if (acc_cnt !== 16'(m_cnt) || acc_cnt4 !== 4'(m_cnt)) begin
                n_err++; $display("FAIL rand_cnt cyc%0d got %0d/%0d want %0d",
                                  c, acc_cnt, acc_cnt4, m_cnt);
            end
        end
        in_valid = 0; rst_n = 1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_sel = '0; in_data = '0; out_ready = '0;
        m_cnt = 0; last_acc = 0;
        for (int i = 0; i < 8; i++) begin
            m_full[i] = 0;
            m_data[i] = 8'h00;
        end
        test_reset();
        test_single_route();
        test_backpressure();
        test_streaming();
        test_counter_wrap();
        test_midstream_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
